// File: rtl/multi_update_generator.sv
// ============================================================================
// Module      : multi_update_generator
// Description : N_CH independent periodic / one-shot update-pulse generators
//               with a shared phase-align sync input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_update_generator #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    N_reset,
    input  logic [N_CH-1:0]         en,
    input  logic [N_CH-1:0]         oneshot,
    input  logic [N_CH-1:0]         retrigger,
    input  logic                    sync,
    input  logic [N_CH*CNT_W-1:0]   t_up,
    output logic [N_CH-1:0]         update,
    output logic [N_CH-1:0]         busy,
    output logic                    update_any
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_CH-1:0] w_fire;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t           r_state;
            logic [CNT_W-1:0] r_cnt;
            logic             r_upd;
            logic             r_busy;
            logic [CNT_W-1:0] w_tup;
            logic             w_tc;

            assign w_tup = t_up[gi*CNT_W +: CNT_W];
            // >= so a lowered period fires on the next edge instead of wrapping
            assign w_tc  = (r_cnt >= w_tup);
            assign w_fire[gi] = N_reset && en[gi] && (r_state == S_RUN) && !sync && w_tc;

            always_ff @(posedge clk) begin
                if (!N_reset || !en[gi]) begin
                    r_state <= S_IDLE;
                    r_cnt   <= c_CNT_ZERO;
                    r_upd   <= 1'b0;
                    r_busy  <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_state <= S_RUN;
                            r_cnt   <= c_CNT_ZERO;
                            r_upd   <= 1'b0;
                            r_busy  <= 1'b1;
                        end
                        S_RUN: begin
                            if (sync) begin
                                r_cnt  <= c_CNT_ZERO;
                                r_upd  <= 1'b0;
                                r_busy <= 1'b1;
                            end else if (w_tc) begin
                                r_cnt   <= c_CNT_ZERO;
                                r_upd   <= 1'b1;
                                r_state <= oneshot[gi] ? S_DONE : S_RUN;
                                r_busy  <= !oneshot[gi];
                            end else begin
                                r_cnt  <= r_cnt + c_CNT_ONE;
                                r_upd  <= 1'b0;
                                r_busy <= 1'b1;
                            end
                        end
                        S_DONE: begin
                            r_cnt   <= c_CNT_ZERO;
                            r_upd   <= 1'b0;
                            r_state <= retrigger[gi] ? S_RUN : S_DONE;
                            r_busy  <= retrigger[gi];
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_cnt   <= c_CNT_ZERO;
                            r_upd   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
            end

            assign update[gi] = r_upd;
            assign busy[gi]   = r_busy;
        end
    endgenerate

    logic r_update_any;

    always_ff @(posedge clk) begin
        if (!N_reset) begin
            r_update_any <= 1'b0;
        end else begin
            r_update_any <= |w_fire;
        end
    end

    assign update_any = r_update_any;

endmodule

`default_nettype wire

// File: doc/multi_update_generator.md
MULTI_UPDATE_GENERATOR -- requirements
Module: multi_update_generator

Interface
REQ-001 Parameter N_CH, default 4: number of independent update channels, legal range 1..32.
REQ-002 Parameter CNT_W, default 32: width of each channel's period and counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 N_reset  input  1  reset, synchronous, active-low: sampled only on rising clk edge, no asynchronous path.
REQ-005 en  input  N_CH  per-channel enable; 0 forces that channel to IDLE.
REQ-006 oneshot  input  N_CH  per-channel mode; 1 = one-shot, 0 = continuous.
REQ-007 retrigger  input  N_CH  per-channel single-cycle pulse restarting a finished one-shot channel.
REQ-008 sync  input  1  global phase-align pulse; zeroes the counter of every RUN channel.
REQ-009 t_up  input  N_CH*CNT_W  per-channel period; channel i uses bits [i*CNT_W +: CNT_W].
REQ-010 update  output  N_CH  per-channel registered single-cycle update pulse.
REQ-011 busy  output  N_CH  1 while channel is in RUN.
REQ-012 update_any  output  1  registered OR of all update bits in the same cycle as update.

Function
REQ-013 Each channel SHALL hold a 2-bit state {IDLE, RUN, DONE} and an unsigned CNT_W-bit counter.
REQ-014 Any state with en[i]=0 SHALL go to IDLE next cycle, counter[i] <= 0, update[i] <= 0.
REQ-015 IDLE with en[i]=1 SHALL go to RUN with counter[i] <= 0; no update in that transition cycle.
REQ-016 RUN, counter[i] >= t_up[i]: counter[i] <= 0, update[i] <= 1; next state RUN if oneshot[i]=0, DONE if oneshot[i]=1.
REQ-017 RUN, counter[i] < t_up[i]: counter[i] <= counter[i]+1, update[i] <= 0.
REQ-018 Comparison SHALL be >=, not ==, so a t_up decrease below the current count yields an update on the next edge instead of a counter wrap.
REQ-019 Continuous-mode period SHALL be t_up+1 cycles; t_up=0 gives update every cycle while in RUN.
REQ-020 First update after IDLE->RUN SHALL occur t_up+1 cycles after the cycle en was first sampled 1.
REQ-021 DONE: update[i]=0, counter held 0; retrigger[i]=1 with en[i]=1 -> RUN, counter 0.
REQ-022 retrigger SHALL be ignored in IDLE and RUN.
REQ-023 sync=1 SHALL set counter[i] <= 0 and update[i] <= 0 for every channel in RUN, overriding REQ-016/017 that cycle; IDLE/DONE channels unaffected.
REQ-024 Priority per channel, highest first: N_reset, en=0, sync, terminal-count compare, increment.
REQ-025 oneshot[i] SHALL be sampled only at the terminal-count edge; changes mid-period take effect at that edge.
REQ-026 Counter SHALL never exceed max(t_up) reached in RUN and SHALL NOT wrap modulo 2^CNT_W; t_up = all-ones is legal (period 2^CNT_W).
REQ-027 busy[i] SHALL equal (state[i]==RUN), registered.
REQ-028 update_any SHALL equal |update in the same cycle.
REQ-029 Channels SHALL be fully independent apart from sync and update_any.

Reset
REQ-030 N_reset=0 at a rising edge: all states IDLE, counters 0, update, busy, update_any 0.
REQ-031 Reset asserted mid-period or in DONE SHALL abort with no trailing update pulse.
REQ-032 First edge with N_reset=1 and en[i]=1 SHALL perform IDLE->RUN per REQ-015.

Verification
REQ-033 N_CH=4, CNT_W=8; ch0 en=1, t_up=3, continuous -> update[0] once every 4 cycles, first 4 cycles after en sampled; busy[0]=1.
REQ-034 ch1 oneshot=1, t_up=5 -> single update[1] 6 cycles after en, then DONE (busy=0); retrigger pulse -> second update 6 cycles later.
REQ-035 ch2 t_up=10, counter at 7, t_up changed to 4 -> update[2] next edge, then period 5.
REQ-036 ch0 t_up=3, ch3 t_up=5, sync pulse mid-count -> both counters 0, then ch0 update 4 cycles and ch3 update 6 cycles after sync; no update on sync cycle even at terminal count.
REQ-037 t_up=0 on ch0 -> update[0]=1 every cycle from second cycle after en; en=0 -> update low next cycle, busy 0.
REQ-038 N_reset=0 for one cycle while ch1 counter at 4 of 5 -> no update, all outputs 0, IDLE->RUN restart, first update 6 cycles after reset released.
